// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store and instruction-fetch bridge between the multicycle
//   control/datapath and a word-wide single-port synchronous RAM. One
//   byte-addressed request is accepted at a time. Stores are lane-replicated
//   with byte enables. Loads return sign/zero-extended data with a one-cycle
//   ready pulse.
//
// Parameters
//   ADDR_W    word-address width of the RAM (2**ADDR_W 32-bit words)
//   READ_LAT  RAM read latency in cycles after mem_en (1..4)
//
// Optional feature macro
//   MISALIGN_TRAP_EN  when defined, a misaligned request skips the RAM and
//                     completes with ready=misaligned=1 one cycle after it is
//                     accepted. When undefined, misaligned is tied low and the
//                     low address bits are ignored as needed.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req, wren         request (held until ready), 1=store / 0=load or fetch
//   funct3            RV32 memory size/sign code (fetch uses 3'b010)
//   addr, wdata       byte address, store data
//   rdata             extended load data, held until the next load completes
//   ready             one-cycle completion pulse
//   misaligned        with ready: request was misaligned (trap build only)
//   mem_en, mem_we    RAM enable / write enable
//   mem_be            RAM byte enables, bit i = byte lane i
//   mem_addr          RAM word address
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data, valid READ_LAT cycles after mem_en

module mem_access_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wren,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              misaligned,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  // Address bits above the RAM word range do not take part in the access.
  generate
    if (ADDR_W + 2 < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[31:ADDR_W+2];
    end
  endgenerate

  // Store lane steering from the live request inputs (funct3[1:0] = size).
  logic [3:0]  st_be_c;
  logic [31:0] st_wdata_c;

  always_comb begin
    st_be_c    = 4'b1111;
    st_wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be_c    = 4'(4'b0001 << addr[1:0]);
        st_wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_c    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        st_be_c    = 4'b1111;
        st_wdata_c = wdata;
      end
    endcase
  end

  // Load extraction from the RAM word using the latched size and byte lane.
  // Reserved codes fall into the default arm and pass the word through.
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

  always_comb begin
    ld_byte_c = mem_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte_c = mem_rdata[7:0];
      2'd1:    ld_byte_c = mem_rdata[15:8];
      2'd2:    ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    ld_half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext_c  = mem_rdata;
    case (funct3_q)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_ext_c = {24'h000000, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_ext_c = {16'h0000, ld_half_c};
      default: ld_ext_c = mem_rdata;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic mis_c;

  // Halfwords need addr[0]=0; word-sized codes (funct3[1]=1) need addr[1:0]=0.
  always_comb begin
    mis_c = 1'b0;
    if (funct3[1]) begin
      mis_c = (addr[1:0] != 2'b00);
    end else if (funct3[0]) begin
      mis_c = addr[0];
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          funct3_d   = funct3;
          lane_d     = addr[1:0];
          mem_addr_d = addr[ADDR_W+1:2];
`ifdef MISALIGN_TRAP_EN
          if (mis_c) begin
            state_d      = RESP;
            ready_d      = 1'b1;
            misaligned_d = 1'b1;
          end else
`endif
          if (wren) begin
            state_d     = WRITE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_be_d    = st_be_c;
            mem_wdata_d = st_wdata_c;
          end else begin
            state_d  = READ;
            mem_en_d = 1'b1;
            mem_be_d = 4'b1111;
            cnt_d    = CNT_W'(READ_LAT);
          end
        end
      end

      // RAM write strobe is high for this single cycle.
      WRITE: begin
        state_d = RESP;
        ready_d = 1'b1;
      end

      // cnt reaches zero in the cycle mem_rdata is valid.
      READ: begin
        if (cnt_q == '0) begin
          rdata_d = ld_ext_c;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // ready is high during RESP; req here is ignored.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      cnt_q       <= '0;
      rdata_q     <= 32'h0;
      ready_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural sync RAM of
// latency RL attached.
module tb_mem_access_unit;

  localparam int unsigned AW = 12;
  localparam int unsigned RL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          wren;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;
  logic          misaligned;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wren       (wren),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .misaligned (misaligned),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // RAM: read data appears RL cycles after the cycle mem_en is high.
  logic [31:0] ram  [0:(1<<AW)-1];
  logic [31:0] pipe [RL];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_rdata = pipe[RL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request; k=1 is the cycle after the accepting edge.
  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        output int lat, output int en_cnt, output logic mis,
                        output logic [31:0] s_we, output logic [31:0] s_be,
                        output logic [31:0] s_addr, output logic [31:0] s_wd);
    @(negedge clk);
    req = 1'b1; wren = w; funct3 = f; addr = a; wdata = d;
    lat = -1; en_cnt = 0; mis = 1'b0;
    s_we = '0; s_be = '0; s_addr = '0; s_wd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (k == 1) begin
        s_we = 32'(mem_we); s_be = 32'(mem_be);
        s_addr = 32'(mem_addr); s_wd = mem_wdata;
      end
      if (ready) begin
        lat = k;
        mis = misaligned;
        break;
      end
    end
    if (!hold) req = 1'b0;
  endtask

  initial begin
    int lat, en_cnt, rdy_cnt;
    logic mis;
    logic [31:0] s_we, s_be, s_addr, s_wd;

    reset = 1'b1; req = 1'b0; wren = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_status", {28'h0, ready, misaligned, mem_en, mem_we}, 32'h0);
    check("rst_be",     32'(mem_be), 32'h0);
    check("rst_addr",   32'(mem_addr), 32'h0);
    check("rst_wdata",  mem_wdata, 32'h0);
    check("rst_rdata",  rdata, 32'h0);
    reset = 1'b0;

    access(1'b1, 3'b010, 32'h00, 32'h11223344, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("sw0_lat", 32'(lat), 32'd2);

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("sw_we",    s_we,   32'h1);
    check("sw_be",    s_be,   32'hF);
    check("sw_addr",  s_addr, 32'h4);
    check("sw_wdata", s_wd,   32'hDEADBEEF);
    check("sw_lat",   32'(lat), 32'd2);
    check("sw_en",    32'(en_cnt), 32'd1);

    access(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("sb_be",    s_be, 32'h8);
    check("sb_wdata", s_wd, 32'hA5A5A5A5);
    check("sb_lat",   32'(lat), 32'd2);

    access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lb_rdata", rdata, 32'hFFFFFFA5);
    check("lb_lat",   32'(lat), 32'(2 + RL));
    check("lb_en",    32'(en_cnt), 32'd1);
    check("lb_we",    s_we, 32'h0);

    access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lbu_rdata", rdata, 32'h000000A5);

    access(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("sh_be",    s_be, 32'hC);
    check("sh_wdata", s_wd, 32'h80018001);
    check("sh_addr",  s_addr, 32'h8);

    access(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lh_rdata", rdata, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lhu_rdata", rdata, 32'h00008001);

    access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lw_rdata", rdata, 32'hA5ADBEEF);
    check("lw_lat",   32'(lat), 32'(2 + RL));
    access(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lb0_rdata", rdata, 32'hFFFFFFEF);
    access(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lhu_hi_rdata", rdata, 32'h0000A5AD);
    access(1'b0, 3'b111, 32'h10, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("rsv_rdata", rdata, 32'hA5ADBEEF);

    access(1'b0, 3'b010, 32'h02, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
`ifdef MISALIGN_TRAP_EN
    check("mis_lw_lat",   32'(lat), 32'd1);
    check("mis_lw_flag",  32'(mis), 32'h1);
    check("mis_lw_en",    32'(en_cnt), 32'd0);
    check("mis_lw_rdata", rdata, 32'hA5ADBEEF);
`else
    check("mis_lw_lat",   32'(lat), 32'(2 + RL));
    check("mis_lw_flag",  32'(mis), 32'h0);
    check("mis_lw_rdata", rdata, 32'h11223344);
`endif

    access(1'b1, 3'b001, 32'h21, 32'h00007777, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
`ifdef MISALIGN_TRAP_EN
    check("mis_sh_lat",  32'(lat), 32'd1);
    check("mis_sh_flag", 32'(mis), 32'h1);
    check("mis_sh_en",   32'(en_cnt), 32'd0);
`else
    check("mis_sh_be",    s_be, 32'h3);
    check("mis_sh_wdata", s_wd, 32'h77777777);
    check("mis_sh_lat",   32'(lat), 32'd2);
    access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("lw20_rdata", rdata, 32'h80017777);
`endif

    // req held through RESP: ignored there, taken again in the next IDLE.
    access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, lat, en_cnt, mis, s_we, s_be, s_addr, s_wd);
    check("b2b_first_rdata", rdata, 32'hA5ADBEEF);
    @(negedge clk);
    check("b2b_idle", {30'h0, ready, mem_en}, 32'h0);
    addr = 32'h00;
    @(negedge clk);
    check("b2b_en", 32'(mem_en), 32'h1);
    req = 1'b0;
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
    check("b2b_lat",   32'(lat), 32'(2 + RL));
    check("b2b_rdata", rdata, 32'h11223344);

    // Reset in the middle of a read aborts it with no completion.
    @(negedge clk);
    req = 1'b1; wren = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    check("abort_en", 32'(mem_en), 32'h1);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_status", {28'h0, ready, misaligned, mem_en, mem_we}, 32'h0);
    check("abort_rdata",  rdata, 32'h0);
    check("abort_be",     32'(mem_be), 32'h0);
    check("abort_addr",   32'(mem_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rdy_cnt = 0;
    en_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
      if (mem_en) en_cnt++;
    end
    check("abort_no_ready", 32'(rdy_cnt), 32'd0);
    check("abort_no_en",    32'(en_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
